// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared states, port indices and request type for the 2:1 masked-memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_e;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_DATA   = 1'b1;

   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_DATA_WIDTH = 32;

   typedef struct packed {
      logic [ARB_ADDR_WIDTH-1:0]   addr;
      logic [ARB_DATA_WIDTH/8-1:0] rmask;
      logic [ARB_DATA_WIDTH/8-1:0] wmask;
      logic [ARB_DATA_WIDTH-1:0]   wdata;
   } arb_req_t;

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational grant choice between ifetch and data ports
// MEM_ARB_ROUND_ROBIN_EN adds a last-granted input; otherwise the data port always wins.
module mem_arb_picker
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic       last_i,
`endif
   input  logic [1:0] active_i,
   output logic       valid_o,
   output logic       grant_o
);

   always_comb begin
      valid_o = |active_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // on contention the port that lost last time goes first
      grant_o = (&active_i) ? ~last_i : active_i[PORT_DATA];
`else
      grant_o = active_i[PORT_DATA];
`endif
   end

endmodule

// File: rtl/mem_arbiter_2to1_w_mask.sv
// rtl/mem_arbiter_2to1_w_mask.sv - 2:1 arbiter onto one masked memory port, registered downstream
// MEM_ARB_ROUND_ROBIN_EN selects round-robin grant instead of data-port priority.
module mem_arbiter_2to1_w_mask
   import mem_arb_pkg::*;
#(
   parameter int  ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int  DATA_WIDTH = ARB_DATA_WIDTH,
   localparam int MW         = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*MW-1:0]         req_rmask,
   input  logic [2*MW-1:0]         req_wmask,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [2*DATA_WIDTH-1:0] req_rdata,
   output logic [1:0]              req_resp,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [MW-1:0]           mem_rmask,
   output logic [MW-1:0]           mem_wmask,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_resp,
   output logic                    proto_err
);

   arb_state_e              state_q;
   logic                    grant_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [MW-1:0]           mem_rmask_q;
   logic [MW-1:0]           mem_wmask_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [2*DATA_WIDTH-1:0] req_rdata_q;
   logic [1:0]              req_resp_q;
   logic                    proto_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                    ptr_q;
`endif

   logic [1:0]              active;
   logic [1:0]              bad;
   logic                    pick_valid;
   logic                    pick_grant;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [MW-1:0]           rmask_d;
   logic [MW-1:0]           wmask_d;
   logic [DATA_WIDTH-1:0]   wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_d;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         active[p] = (|req_rmask[p*MW +: MW]) | (|req_wmask[p*MW +: MW]);
         bad[p]    = $isunknown({req_rmask[p*MW +: MW], req_wmask[p*MW +: MW]})
                   | (active[p] & (((|req_rmask[p*MW +: MW]) & (|req_wmask[p*MW +: MW]))
                                   | (req_addr[p*ADDR_WIDTH +: 2] != 2'b00)));
      end
   end

   mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_i   (ptr_q),
`endif
      .active_i (active),
      .valid_o  (pick_valid),
      .grant_o  (pick_grant)
   );

   always_comb begin
      addr_d  = pick_grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      rmask_d = pick_grant ? req_rmask[2*MW-1:MW]                : req_rmask[MW-1:0];
      wmask_d = pick_grant ? req_wmask[2*MW-1:MW]                : req_wmask[MW-1:0];
      wdata_d = pick_grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      // a port presenting both masks is serviced as a write only
      if (|wmask_d) rmask_d = '0;
      rdata_d = (|mem_rmask_q) ? mem_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         grant_q     <= PORT_IFETCH;
         mem_addr_q  <= '0;
         mem_rmask_q <= '0;
         mem_wmask_q <= '0;
         mem_wdata_q <= '0;
         req_rdata_q <= '0;
         req_resp_q  <= '0;
         proto_err_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (mem_resp || (|bad)) proto_err_q <= 1'b1;
               if (pick_valid) begin
                  grant_q     <= pick_grant;
                  mem_addr_q  <= addr_d;
                  mem_rmask_q <= rmask_d;
                  mem_wmask_q <= wmask_d;
                  mem_wdata_q <= wdata_d;
                  state_q     <= ARB_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  ptr_q       <= pick_grant;
`endif
               end
            end
            ARB_ISSUE: begin
               if (mem_resp) begin
                  mem_rmask_q <= '0;
                  mem_wmask_q <= '0;
                  if (grant_q) req_rdata_q[2*DATA_WIDTH-1:DATA_WIDTH] <= rdata_d;
                  else         req_rdata_q[DATA_WIDTH-1:0]            <= rdata_d;
                  req_resp_q[grant_q] <= 1'b1;
                  state_q             <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (mem_resp) proto_err_q <= 1'b1;
               req_resp_q <= '0;
               state_q    <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign req_rdata = req_rdata_q;
   assign req_resp  = req_resp_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rmask = mem_rmask_q;
   assign mem_wmask = mem_wmask_q;
   assign mem_wdata = mem_wdata_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter_2to1_w_mask.sv
// tb/tb_mem_arbiter_2to1_w_mask.sv - randomized self-checking bench with a word-array memory and reference store
module tb_mem_arbiter_2to1_w_mask;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] p_addr  [2];
   logic [3:0]  p_rmask [2];
   logic [3:0]  p_wmask [2];
   logic [31:0] p_wdata [2];

   logic [63:0] req_addr, req_wdata, req_rdata;
   logic [7:0]  req_rmask, req_wmask;
   logic [1:0]  req_resp;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_rmask, mem_wmask;
   logic        mem_resp, mem_resp_m, stray_resp, proto_err;

   assign req_addr  = {p_addr[1],  p_addr[0]};
   assign req_rmask = {p_rmask[1], p_rmask[0]};
   assign req_wmask = {p_wmask[1], p_wmask[0]};
   assign req_wdata = {p_wdata[1], p_wdata[0]};
   assign mem_resp  = mem_resp_m | stray_resp;

   mem_arbiter_2to1_w_mask dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_addr  (req_addr),
      .req_rmask (req_rmask),
      .req_wmask (req_wmask),
      .req_wdata (req_wdata),
      .req_rdata (req_rdata),
      .req_resp  (req_resp),
      .mem_addr  (mem_addr),
      .mem_rmask (mem_rmask),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   logic [31:0] mem_arr [1024];
   logic [31:0] ref_mem [1024];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, last_resp_cyc = 0, have_resp = 0, prev_act = 0;
   int addr_changed = 0, rw_both = 0, lat_cfg = 0, last_port = 0;
   int order[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // memory: answers L cycles after a request appears, flags address motion
   int m_cnt = 0, m_lat = 3;
   logic [31:0] m_addr;
   always @(negedge clk) begin
      if (!rst_n || (mem_rmask == 4'h0 && mem_wmask == 4'h0) || mem_resp_m) begin
         mem_resp_m = 1'b0;
         m_cnt      = 0;
      end else begin
         if (m_cnt == 0) begin
            m_addr = mem_addr;
            m_lat  = (lat_cfg == 0) ? 3 : int'($urandom_range(1, 4));
            if (mem_rmask != 4'h0 && mem_wmask != 4'h0) rw_both++;
         end else if (mem_addr != m_addr) addr_changed++;
         if (m_cnt == m_lat) begin
            if (mem_wmask != 4'h0) begin
               for (int b = 0; b < 4; b++)
                  if (mem_wmask[b]) mem_arr[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else mem_rdata = mem_arr[mem_addr[11:2]];
            mem_resp_m = 1'b1;
         end else m_cnt++;
      end
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst_n) begin
         if (req_resp != 2'b00) begin
            chk("resp_onehot", 64'($countones(req_resp)), 64'd1);
            chk("mask_clear_at_resp", {mem_rmask, mem_wmask}, 64'd0);
            last_resp_cyc = cyc;
            have_resp     = 1;
         end
         if ((mem_rmask | mem_wmask) != 4'h0 && prev_act == 0 && have_resp != 0)
            chk("grant_gap_ge2", 64'((cyc - last_resp_cyc) >= 2), 64'd1);
         prev_act = ((mem_rmask | mem_wmask) != 4'h0) ? 1 : 0;
      end else begin
         prev_act  = 0;
         have_resp = 0;
      end
   end

   function automatic arb_req_t rand_req();
      arb_req_t q;
      logic [3:0] m;
      q.addr  = 32'($urandom_range(0, 63)) << 2;
      q.wdata = $urandom;
      m       = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin q.rmask = m; q.wmask = 4'h0; end
      else                           begin q.rmask = 4'h0; q.wmask = m; end
      return q;
   endfunction

   task automatic issue(input int p, input arb_req_t r, input bit chg,
                        output logic [31:0] rd, output int lat);
      int moved;
      moved      = 0;
      p_addr[p]  = r.addr;
      p_rmask[p] = r.rmask;
      p_wmask[p] = r.wmask;
      p_wdata[p] = r.wdata;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (chg && lat == 1) p_addr[p] = r.addr ^ 32'h4;
         if (chg && (mem_rmask | mem_wmask) != 4'h0 && mem_addr != r.addr) moved++;
      end while (req_resp[p] !== 1'b1 && lat < 100);
      rd = (p == 1) ? req_rdata[63:32] : req_rdata[31:0];
      chk($sformatf("resp_seen_p%0d", p), {63'd0, req_resp[p]}, 64'd1);
      if (req_resp[p] === 1'b1) begin
         last_port = p;
         order.push_back(p);
         if (r.wmask != 4'h0) begin
            chk("wr_rdata_zero", rd, 64'd0);
            for (int b = 0; b < 4; b++)
               if (r.wmask[b]) ref_mem[r.addr[11:2]][8*b +: 8] = r.wdata[8*b +: 8];
         end else chk($sformatf("rd_data_p%0d", p), rd, ref_mem[r.addr[11:2]]);
      end
      if (chg) chk("addr_held", 64'(moved), 64'd0);
      @(posedge clk); #1;
      chk("resp_one_cycle", {63'd0, req_resp[p]}, 64'd0);
      p_rmask[p] = 4'h0;
      p_wmask[p] = 4'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         p_addr[p] = '0; p_rmask[p] = '0; p_wmask[p] = '0; p_wdata[p] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      last_port = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      arb_req_t    r;
      logic [31:0] rd, rd1, old, a;
      int          lat, lat1, exp_first, stray;

      stray_resp = 1'b0;
      mem_resp_m = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      a = 32'h0000_1000;
      mem_arr[a[11:2]] = 32'hDEAD_BEEF;
      ref_mem[a[11:2]] = 32'hDEAD_BEEF;

      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         p_addr[p] = '0; p_rmask[p] = '0; p_wmask[p] = '0; p_wdata[p] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_masks", {mem_rmask, mem_wmask}, 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_resp", req_resp, 64'd0);
      chk("rst_rdata", req_rdata, 64'd0);
      chk("rst_proto_err", proto_err, 64'd0);
      rst_n = 1'b1;

      r = '{addr: 32'h0000_1000, rmask: 4'hF, wmask: 4'h0, wdata: 32'h0};
      fork
         issue(0, r, 1'b0, rd, lat);
         begin
            @(posedge clk); #1;
            chk("t1_mem_rmask_e0", mem_rmask, 64'hF);
            chk("t1_mem_addr_e0", mem_addr, 64'h1000);
         end
      join
      chk("t1_rdata", rd, 64'hDEAD_BEEF);
      chk("t1_latency", 64'(lat - 1), 64'd4);

      a   = 32'h0000_2004;
      old = ref_mem[a[11:2]];
      r   = '{addr: a, rmask: 4'h0, wmask: 4'b0011, wdata: 32'h1234_5678};
      issue(1, r, 1'b0, rd, lat);
      r.wmask = 4'h0;
      r.rmask = 4'hF;
      issue(1, r, 1'b0, rd, lat);
      chk("t2_byte_merge", rd, {32'd0, old[31:16], 16'h5678});

      for (int k = 0; k < 10; k++) begin
         order.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_first = (last_port == 1) ? 0 : 1;
`else
         exp_first = 1;
`endif
         fork
            issue(0, rand_req(), 1'b0, rd, lat);
            issue(1, rand_req(), 1'b0, rd1, lat1);
         join
         chk($sformatf("simul_first_r%0d", k), 64'(order[0]), 64'(exp_first));
      end

      lat_cfg = 1;
      for (int k = 0; k < 60; k++) begin
         fork
            begin
               if ($urandom_range(0, 3) != 0) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  issue(0, rand_req(), 1'b0, rd, lat);
               end
            end
            begin
               if ($urandom_range(0, 3) != 0) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  issue(1, rand_req(), 1'b0, rd1, lat1);
               end
            end
         join
      end
      chk("rand_proto_clean", proto_err, 64'd0);
      chk("rand_no_rw_both", 64'(rw_both), 64'd0);

      lat_cfg = 0;
      r = '{addr: 32'h0000_0200, rmask: 4'hF, wmask: 4'h0, wdata: 32'h0};
      issue(0, r, 1'b1, rd, lat);
      chk("addr_change_mem_ok", 64'(addr_changed), 64'd0);

      r = '{addr: 32'h0000_0030, rmask: 4'hF, wmask: 4'hF, wdata: 32'hCAFE_F00D};
      issue(0, r, 1'b0, rd, lat);
      chk("pe_both_masks", proto_err, 64'd1);
      chk("pe_no_rw_both", 64'(rw_both), 64'd0);
      r.wmask = 4'h0;
      issue(0, r, 1'b0, rd, lat);
      chk("pe_done_as_write", rd, 64'hCAFE_F00D);
      chk("pe_sticky", proto_err, 64'd1);
      do_reset();
      chk("pe_reset_clear", proto_err, 64'd0);
      r = '{addr: 32'h0000_0041, rmask: 4'hF, wmask: 4'h0, wdata: 32'h0};
      issue(0, r, 1'b0, rd, lat);
      chk("pe_misaligned", proto_err, 64'd1);
      do_reset();
      stray_resp = 1'b1;
      @(posedge clk); #1;
      stray_resp = 1'b0;
      chk("pe_stray_resp", proto_err, 64'd1);
      do_reset();

      p_addr[0]  = 32'h0000_0100;
      p_rmask[0] = 4'hF;
      @(posedge clk); #1;
      chk("ri_granted", mem_rmask, 64'hF);
      @(posedge clk); #1;
      rst_n      = 1'b0;
      p_rmask[0] = 4'h0;
      @(posedge clk); #1;
      chk("ri_masks", {mem_rmask, mem_wmask}, 64'd0);
      chk("ri_resp", req_resp, 64'd0);
      chk("ri_addr", mem_addr, 64'd0);
      rst_n     = 1'b1;
      last_port = 0;
      stray     = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (req_resp != 2'b00) stray++;
      end
      chk("ri_no_stray_resp", 64'(stray), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
